// File: rtl/matrix_uart_tx.sv
// Serialises a 4x4 byte result matrix row-major over an 8N1 UART line after a start strobe.
// Define MATRIX_TX_HEADER_EN to frame the 16 bytes with a 0xA5 sync byte and an XOR checksum byte.
//
// state | meaning
// IDLE  | line high, waiting for start
// START | start bit (low) of the current byte
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high), then next byte or frame end
module matrix_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] matrix,
  output logic         busy,
  output logic         done,
  output logic         tx,
  output logic [3:0]   byte_idx
);

`ifdef MATRIX_TX_HEADER_EN
  localparam int FRAME_BYTES = NUM_BYTES + 2;
`else
  localparam int FRAME_BYTES = NUM_BYTES;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_d;
  logic [15:0]    baud_cnt;
  logic [2:0]     bit_cnt;
  logic [4:0]     seq;
  logic [7:0]     shreg;
  logic [7:0]     next_byte;
  logic [7:0]     first_byte;
  logic [127:0]   snap;
  logic           bit_end;
  logic           accept;
  logic           last_byte;

  assign bit_end   = (baud_cnt == 16'(CLKS_PER_BIT - 1));
  // The done cycle already has busy low, but a start there is still ignored.
  assign accept    = start && (state == IDLE) && !done;
  assign last_byte = (seq == 5'(FRAME_BYTES - 1));

`ifdef MATRIX_TX_HEADER_EN
  logic [7:0] csum;
  logic [4:0] seq_n;

  always_comb begin
    csum = '0;
    for (int i = 0; i < 16; i++) csum = csum ^ snap[8*i +: 8];
  end

  always_comb begin
    seq_n = seq + 5'd1;
    if (seq_n == 5'(FRAME_BYTES - 1)) next_byte = csum;
    else next_byte = snap[{4'd15 - 4'(seq_n - 5'd1), 3'b000} +: 8];
  end

  assign first_byte = 8'hA5;
  assign byte_idx   = (seq == 5'd0 || last_byte) ? 4'd0 : 4'(seq - 5'd1);
`else
  always_comb begin
    next_byte = snap[{4'd15 - (seq[3:0] + 4'd1), 3'b000} +: 8];
  end

  assign first_byte = matrix[127:120];
  assign byte_idx   = seq[3:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_d = STOP;
      STOP:  if (bit_end) state_d = last_byte ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      seq      <= '0;
      shreg    <= '0;
      snap     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          if (accept) begin
            snap  <= matrix;
            shreg <= first_byte;
            seq   <= '0;
            busy  <= 1'b1;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            tx      <= (bit_cnt == 3'd7) ? 1'b1 : shreg[1];
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_byte) begin
              seq  <= '0;
              busy <= 1'b0;
              done <= 1'b1;
              tx   <= 1'b1;
            end else begin
              seq   <= seq + 5'd1;
              shreg <= next_byte;
              tx    <= 1'b0;
            end
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_uart_tx.sv
// Bench for matrix_uart_tx: per-cycle comparison against a frame-position model plus
// UART decoding of the line; follows MATRIX_TX_HEADER_EN when defined.
module tb_matrix_uart_tx;
  localparam int CPB = 4;
`ifdef MATRIX_TX_HEADER_EN
  localparam int FB  = 18;
  localparam bit HDR = 1'b1;
`else
  localparam int FB  = 16;
  localparam bit HDR = 1'b0;
`endif
  localparam int FLEN = FB * 10 * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] matrix = '0;
  logic         busy, done, tx;
  logic [3:0]   byte_idx;

  matrix_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix),
    .busy(busy), .done(done), .tx(tx), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ndone = 0;
  logic [7:0] rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Byte i of the transmitted frame for a given matrix snapshot.
  function automatic logic [7:0] frame_byte(input logic [127:0] m, input int i);
    logic [7:0] x;
    x = 8'h00;
    if (HDR) begin
      if (i == 0) return 8'hA5;
      if (i == FB - 1) begin
        for (int j = 0; j < 16; j++) x = x ^ m[127 - 8*j -: 8];
        return x;
      end
      return m[127 - 8*(i-1) -: 8];
    end
    return m[127 - 8*i -: 8];
  endfunction

  // Model: position k within the frame, counted in clock cycles since busy rose.
  bit           act = 1'b0;
  bit           done_m = 1'b0;
  int           k = 0;
  logic [127:0] msnap = '0;

  always @(posedge clk or negedge rst) begin
    bit was_done;
    if (!rst) begin
      act = 1'b0; done_m = 1'b0; k = 0;
    end else begin
      was_done = done_m;
      done_m = 1'b0;
      if (act) begin
        k++;
        if (k == FLEN) begin act = 1'b0; done_m = 1'b1; end
      end else if (start && !was_done) begin
        act = 1'b1; k = 0; msnap = matrix;
      end
    end
  end

  always @(negedge clk) begin
    logic       etx, ebusy;
    logic [3:0] eidx;
    logic [7:0] eb;
    int         pos, bn;
    etx = 1'b1; ebusy = 1'b0; eidx = 4'd0;
    if (act) begin
      pos = k / (10*CPB);
      bn  = (k % (10*CPB)) / CPB;
      eb  = frame_byte(msnap, pos);
      etx = (bn == 0) ? 1'b0 : (bn == 9) ? 1'b1 : eb[bn-1];
      ebusy = 1'b1;
      if (HDR) eidx = (pos == 0 || pos == FB-1) ? 4'd0 : 4'(pos - 1);
      else     eidx = 4'(pos);
    end
    total++;
    if ({tx, busy, done, byte_idx} !== {etx, ebusy, done_m, eidx}) begin
      bad++;
      $display("FAIL cycle_model t=%0t tx=%b/%b busy=%b/%b done=%b/%b idx=%0d/%0d",
               $time, tx, etx, busy, ebusy, done, done_m, byte_idx, eidx);
    end
    if (done === 1'b1) ndone++;
  end

  task automatic pulse_start(input logic [127:0] m);
    @(negedge clk);
    matrix = m;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Decode nb bytes from the line, sampling mid-bit on negedges.
  task automatic rx_frame(input int nb);
    logic [7:0] d;
    int w;
    rx.delete();
    for (int b = 0; b < nb; b++) begin
      w = 0;
      while (tx !== 1'b0 && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) begin
        total++; bad++;
        $display("FAIL rx_start_timeout actual=none expected=start_bit byte=%0d", b);
        return;
      end
      repeat (2) @(negedge clk);
      check("rx_start_bit", tx, 0);
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        d[j] = tx;
      end
      repeat (CPB) @(negedge clk);
      check("rx_stop_bit", tx, 1);
      rx.push_back(d);
    end
  endtask

  task automatic check_rx(input string name, input logic [127:0] m);
    check({name, "_count"}, rx.size(), FB);
    for (int i = 0; i < FB && i < rx.size(); i++) check(name, rx[i], frame_byte(m, i));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] m;
    logic [9:0]   line;
    int           lat, n, nd0;

    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_idx", byte_idx, 0);
    end

    // Basic frame and done latency
    m = 128'h000102030405060708090A0B0C0D0E0F;
    pulse_start(m);
    lat = 0;
    fork
      rx_frame(FB);
      begin
        while (done !== 1'b1 && lat < 5000) begin @(negedge clk); lat++; end
        @(negedge clk);
        check("done_one_cycle", done, 0);
      end
    join
    check("done_latency", lat, FLEN);
`ifdef MATRIX_TX_HEADER_EN
    check("hdr_sync", rx[0], 8'hA5);
    for (int i = 0; i < 16; i++) check("basic_byte", rx[i+1], i);
    check("hdr_csum_seq", rx[17], 8'h00);
`else
    for (int i = 0; i < 16; i++) check("basic_byte", rx[i], i);
`endif
    wait_idle();

    // First-byte line sequence for 0xA5
    pulse_start({8'hA5, 120'h0});
    repeat (2) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      line[j] = tx;
      repeat (CPB) @(negedge clk);
    end
    check("a5_line", line, 10'b11_0100_1010);
    wait_idle();

    // Start while busy is ignored; only one done
    m = {$urandom, $urandom, $urandom, $urandom};
    nd0 = ndone;
    pulse_start(m);
    fork
      rx_frame(FB);
      begin repeat (98) @(negedge clk); pulse_start('1); end
    join
    check_rx("ignore_busy_byte", m);
    wait_idle();
    repeat (5) @(negedge clk);
    check("ignore_busy_done_count", ndone - nd0, 1);

    // Start in the done cycle is ignored; accepted afterwards
    pulse_start(128'h1);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    start = 1'b1;
    matrix = 128'h5;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_busy", busy, 0);
    pulse_start(128'h7);
    check("start_after_done_busy", busy, 1);
    wait_idle();

    // Reset mid-frame during byte 5
    m = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(m);
    repeat (5*10*CPB + 10) @(negedge clk);
    check("mid_idx", byte_idx, HDR ? 4 : 5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", byte_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(m);
    rx_frame(FB);
    check_rx("after_rst_byte", m);
    wait_idle();

`ifdef MATRIX_TX_HEADER_EN
    pulse_start({16{8'h01}});
    rx_frame(FB);
    check("csum_all_01", rx[17], 8'h00);
    wait_idle();
    pulse_start({8'h01, 120'h0});
    rx_frame(FB);
    check("csum_single_01", rx[17], 8'h01);
    wait_idle();
`endif

    // Randomized frames with spurious starts and idle gaps
    for (int r = 0; r < 4; r++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 20)) @(negedge clk);
      pulse_start(m);
      fork
        rx_frame(FB);
        begin repeat ($urandom_range(20, 500)) @(negedge clk); pulse_start(~m); end
      join
      check_rx("rand_byte", m);
      wait_idle();
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
